sha256_arbiter: RTL and testbench

SHA256_ARBITER -- requirements
Module: sha256_arbiter

---
 rtl/sha256_arbiter.sv | 127 ++++++++++++
 tb/tb_sha256_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter that time-shares one combinational SHA256 core among N_REQ requesters.
// A granted block is registered onto core_in, the core is given SETTLE_CYCLES to settle, and the digest is then held until the consumer takes it.
module sha256_arbiter #(
    parameter int N_REQ         = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*512-1:0]       req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [511:0]               core_in,
    input  logic [255:0]               core_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [255:0]               rsp_digest,
    output logic                       busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = 8;

    // Handshake: block i moves on the rising edge where req_valid[i] && req_ready[i];
    // the digest moves on the rising edge where rsp_valid && rsp_ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ID_W-1:0]   last_grant;
    logic              sel_found;
    logic [ID_W-1:0]   sel_idx;
    logic [ID_W-1:0]   cand_idx;
    logic [511:0]      sel_data;
    logic              accept;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand_idx = ID_W'((int'(last_grant) + off) % N_REQ);
            if (!sel_found && req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == sel_idx) begin
                sel_data = req_data[i*512 +: 512];
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found && !reset) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (ID_W'(i) == sel_idx);
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            core_in    <= '0;
            rsp_digest <= '0;
            rsp_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                core_in    <= sel_data;
                rsp_id     <= sel_idx;
                last_grant <= sel_idx;
            end
            // Capture on the last settle edge so the digest reflects a fully settled core.
            if (state == SETTLE && cnt == '0) begin
                rsp_digest <= core_out;
            end
        end
    end

endmodule

// File: tb/tb_sha256_arbiter.sv
// Bench for sha256_arbiter with two requesters and a stand-in core that knows the "abc" digest.
// A vector table drives the grant sequence; hand sequences cover reset, backpressure and dropped requests.
module tb_sha256_arbiter;

    localparam int N_REQ  = 2;
    localparam int SETTLE = 4;

    localparam logic [511:0] ABC_BLOCK  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1023:0]    req_data;
    logic [1:0]       req_ready;
    logic [511:0]     core_in;
    logic [255:0]     core_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [0:0]       rsp_id;
    logic [255:0]     rsp_digest;
    logic             busy;

    logic [511:0]     blk [2];
    logic [256:0]     exp_q [$];
    int               n_vec;
    int               n_err;
    int               cyc;
    int               last_acc;

    typedef struct {
        logic [1:0] valid;
        int         exp_id;
        int         bp;
        bit         pulse;
    } vec_t;

    vec_t tbl [7];

    sha256_arbiter #(.N_REQ(N_REQ), .SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .core_in    (core_in),
        .core_out   (core_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_digest (rsp_digest),
        .busy       (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: real digest for "abc", an arbitrary mixing function otherwise.
    function automatic logic [255:0] core_model(input logic [511:0] b);
        logic [255:0] x;
        if (b == ABC_BLOCK) return ABC_DIGEST;
        x = b[511:256] ^ {b[238:0], b[255:239]};
        return x ^ 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    endfunction

    assign core_out = core_model(core_in);
    assign req_data = {blk[1], blk[0]};

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ctrl", {req_ready, rsp_valid, busy}, 4'b0000);
        chk("rst_core_in", core_in, '0);
        chk("rst_digest", rsp_digest, '0);
        chk("rst_id", rsp_id, '0);
    endtask

    task automatic new_blocks();
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++) blk[i][w*32 +: 32] = $urandom;
    endtask

    // Driver: entered just after a rising edge with the DUT idle; returns just after the handshake edge.
    task automatic do_txn(input logic [1:0] v, input int exp_id, input int bp,
                          input bit pulse, input bit chk_gap);
        logic [256:0] e;
        logic [255:0] h_dig;
        logic [0:0]   h_id;
        int           t_acc;
        bit           seen;
        req_valid = v;
        @(negedge clk);
        chk("idle_before", {rsp_valid, busy}, 2'b00);
        chk("grant", req_ready, 2'b01 << exp_id);
        exp_q.push_back({1'(exp_id), core_model(blk[exp_id])});
        @(posedge clk);
        #1;
        t_acc = cyc;
        // Accepts are separated by SETTLE+1 idle cycles, i.e. SETTLE+2 edges.
        if (chk_gap) chk("accept_gap", t_acc - last_acc, SETTLE + 2);
        last_acc = t_acc;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (pulse && n == 1) req_valid = v | 2'b10;
            if (pulse && n == 2) req_valid = v;
            if (rsp_valid) seen = 1'b1;
            else chk("settle_quiet", {req_ready, busy}, 3'b001);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: no rsp_valid within 20 cycles for requester %0d", exp_id);
            void'(exp_q.pop_front());
            return;
        end
        chk("latency", cyc - t_acc, SETTLE);
        chk("core_in_hold", core_in, blk[exp_id]);
        h_dig = rsp_digest;
        h_id  = rsp_id;
        for (int n = 0; n < bp; n++) begin
            @(negedge clk);
            chk("bp_stable", {rsp_valid, rsp_id, rsp_digest}, {1'b1, h_id, h_dig});
            chk("bp_ctrl", {req_ready, busy}, 3'b001);
            chk("bp_core_in", core_in, blk[exp_id]);
        end
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        chk("rsp", {rsp_id, rsp_digest}, e);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        last_acc  = 0;
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        blk[0]    = ABC_BLOCK;
        blk[1]    = '0;
        tbl[0] = '{2'b01, 0, 0,  1'b0};
        tbl[1] = '{2'b11, 1, 10, 1'b0};
        tbl[2] = '{2'b10, 1, 0,  1'b0};
        tbl[3] = '{2'b11, 0, 0,  1'b0};
        tbl[4] = '{2'b01, 0, 0,  1'b1};
        tbl[5] = '{2'b10, 1, 3,  1'b0};
        tbl[6] = '{2'b11, 0, 0,  1'b0};

        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals();

        // Single "abc" request from requester 0, accepted on the first edge after reset.
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_txn(2'b01, 0, 0, 1'b0, 1'b0);
        req_valid = 2'b00;

        // Fresh reset, then both requesters held for six transactions.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        new_blocks();
        for (int k = 0; k < 6; k++) begin
            do_txn(2'b11, k % 2, 0, 1'b0, k != 0);
        end

        // Table-driven vectors; the grant pointer now sits on requester 1.
        for (int k = 0; k < 7; k++) begin
            new_blocks();
            do_txn(tbl[k].valid, tbl[k].exp_id, tbl[k].bp, tbl[k].pulse, 1'b0);
            if (tbl[k].pulse) begin
                req_valid = 2'b00;
                repeat (3) begin
                    @(negedge clk);
                    chk("pulse_ignored", {req_ready, rsp_valid, busy}, 4'b0000);
                end
                @(posedge clk);
                #1;
            end
        end

        // Reset mid-SETTLE (cnt==2) abandons the transaction.
        new_blocks();
        req_valid = 2'b11;
        @(negedge clk);
        chk("abort_grant", req_ready, 2'b10);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals();
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_rsp", {rsp_valid, busy}, 2'b00);
        end
        @(posedge clk);
        #1;
        do_txn(2'b11, 0, 0, 1'b0, 1'b0);
        req_valid = 2'b00;

        repeat (2) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("final_idle", {req_ready, rsp_valid, busy}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
